// File: rtl/alu_hs.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift ops plus a
// multi-cycle shift-add multiplier; result and flags held until consumed.
module alu_hs #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fun_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned AW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   add_c, sub_c;
  logic [SHW-1:0]   sh_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_cout_c, alu_ovf_c;

  // Single-cycle datapath, evaluated on the live operands at acceptance.
  always_comb begin
    add_c      = {1'b0, in_a} + {1'b0, in_b};
    sub_c      = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
    sh_c       = in_b[SHW-1:0];
    alu_res_c  = '0;
    alu_cout_c = 1'b0;
    alu_ovf_c  = 1'b0;
    case (fun_sel)
      OP_ADD: begin
        alu_res_c  = add_c[WIDTH-1:0];
        alu_cout_c = add_c[WIDTH];
        alu_ovf_c  = (in_a[MSB] == in_b[MSB]) && (add_c[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        alu_res_c  = sub_c[WIDTH-1:0];
        alu_cout_c = sub_c[WIDTH];
        alu_ovf_c  = (in_a[MSB] != in_b[MSB]) && (sub_c[MSB] != in_a[MSB]);
      end
      OP_NOT:  alu_res_c = ~in_a;
      OP_AND:  alu_res_c = in_a & in_b;
      OP_OR:   alu_res_c = in_a | in_b;
      OP_XOR:  alu_res_c = in_a ^ in_b;
      OP_SLT:  alu_res_c = WIDTH'($signed(in_a) < $signed(in_b));
      OP_EQ:   alu_res_c = WIDTH'(in_a == in_b);
      OP_SLTU: alu_res_c = WIDTH'(in_a < in_b);
      OP_SLL:  alu_res_c = in_a << sh_c;
      OP_SRL:  alu_res_c = in_a >> sh_c;
      OP_SRA:  alu_res_c = WIDTH'($signed(in_a) >>> sh_c);
      default: alu_res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (fun_sel == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = in_a;
            mplier_d = in_b;
            cnt_d    = '0;
            acc_d    = '0;
          end else begin
            state_d     = S_DONE;
            res_d       = alu_res_c;
            cout_d      = alu_cout_c;
            ovf_d       = alu_ovf_c;
            zero_d      = (alu_res_c == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        // One multiplier bit per cycle; the last iteration latches the result.
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + (AW'(mcand_q) << cnt_q);
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          res_d       = acc_d[WIDTH-1:0];
          cout_d      = 1'b0;
          ovf_d       = |acc_d[AW-1:WIDTH];
          zero_d      = (acc_d[WIDTH-1:0] == '0);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
